// File: rtl/la_iosupseq.sv
// Supply/ground channel power sequencer: ramps channels up in order, down in reverse.
// Define LA_IOSUPSEQ_SYNC_EN to pass pgood through a 2-flop synchronizer.
module la_iosupseq #(
    parameter     PROP  = "DEFAULT",
    parameter     SIDE  = "NO",
    parameter int RINGW = 8,
    parameter int N     = 4,
    parameter int DW    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DW-1:0]    delay,
    input  logic [N-1:0]     pgood,
    output logic [N-1:0]     chen,
    output logic             ready,
    output logic             fault,
    inout  wire              vdd,
    inout  wire              vss,
    inout  wire              vddio,
    inout  wire              vssio,
    inout  wire [RINGW-1:0]  ioring
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [2:0] {IDLE, RAMP, ON, DOWN, FAULT} state_t;

    state_t          state, state_d;
    logic [IW-1:0]   idx, idx_d;
    logic [DW-1:0]   cnt, cnt_d;
    logic [N-1:0]    chen_d;
    logic            ready_d, fault_d;
    logic            step;
    logic [N-1:0]    pgood_s;

`ifdef LA_IOSUPSEQ_SYNC_EN
    logic [N-1:0] sync1, sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pgood;
            sync2 <= sync1;
        end
    end

    assign pgood_s = sync2;
`else
    assign pgood_s = pgood;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
            chen  <= '0;
            ready <= 1'b0;
            fault <= 1'b0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            cnt   <= cnt_d;
            chen  <= chen_d;
            ready <= ready_d;
            fault <= fault_d;
        end
    end

    // A failing pgood check at step time beats a simultaneous en=0 abort.
    always_comb begin
        state_d = state;
        idx_d   = idx;
        cnt_d   = cnt;
        step    = (cnt == delay);
        unique case (state)
            IDLE: begin
                if (en) begin
                    state_d = RAMP;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            RAMP: begin
                if (step && !pgood_s[idx]) begin
                    state_d = FAULT;
                end else if (!en) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                end else if (step) begin
                    if (idx == LAST) begin
                        state_d = ON;
                    end else begin
                        idx_d = idx + 1'b1;
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            ON: begin
                if (!(&pgood_s)) begin
                    state_d = FAULT;
                end else if (!en) begin
                    state_d = DOWN;
                    idx_d   = LAST;
                    cnt_d   = '0;
                end
            end
            DOWN: begin
                if (step) begin
                    cnt_d = '0;
                    if (idx == '0) state_d = IDLE;
                    else           idx_d   = idx - 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            FAULT: begin
                if (!en) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register on the transition edge.
    always_comb begin
        chen_d  = '0;
        ready_d = 1'b0;
        fault_d = 1'b0;
        case (state_d)
            RAMP, DOWN: begin
                for (int unsigned j = 0; j < N; j++) begin
                    chen_d[j] = (j <= 32'(idx_d));
                end
            end
            ON: begin
                chen_d  = '1;
                ready_d = 1'b1;
            end
            FAULT: fault_d = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_la_iosupseq.sv
// Directed bench for la_iosupseq (N=4, DW=8): power-up/down, faults, abort, reset, delay wrap.
module tb_la_iosupseq;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [7:0] delay;
    logic [3:0] pgood;
    logic [3:0] chen;
    logic       ready;
    logic       fault;
    wire        vdd, vss, vddio, vssio;
    wire  [7:0] ioring;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef LA_IOSUPSEQ_SYNC_EN
    localparam int BL = 3;
`else
    localparam int BL = 1;
`endif

    la_iosupseq #(.PROP("DEFAULT"), .SIDE("NO"), .RINGW(8), .N(4), .DW(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .delay  (delay),
        .pgood  (pgood),
        .chen   (chen),
        .ready  (ready),
        .fault  (fault),
        .vdd    (vdd),
        .vss    (vss),
        .vddio  (vddio),
        .vssio  (vssio),
        .ioring (ioring)
    );

    always #5 clk = ~clk;

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] c, input logic r, input logic f);
        chk({tag, ".chen"}, 32'(chen), 32'(c));
        chk({tag, ".ready"}, 32'(ready), 32'(r));
        chk({tag, ".fault"}, 32'(fault), 32'(f));
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; delay = 8'd3; pgood = 4'b0000;
        ticks(2);
        reset = 1'b0;
        chk_out("reset", 4'b0000, 1'b0, 1'b0);

        // power-up, delay=3
        pgood = 4'b1111; en = 1'b1;
        ticks(1);  chk_out("up_E", 4'b0001, 1'b0, 1'b0);
        ticks(3);  chk("up_E3.chen", 32'(chen), 32'h1);
        ticks(1);  chk("up_E4.chen", 32'(chen), 32'h3);
        ticks(4);  chk("up_E8.chen", 32'(chen), 32'h7);
        ticks(4);  chk_out("up_E12", 4'b1111, 1'b0, 1'b0);
        ticks(3);  chk("up_E15.ready", 32'(ready), 32'h0);
        ticks(1);  chk_out("up_E16", 4'b1111, 1'b1, 1'b0);

        // power-down; en=1 mid-DOWN is ignored until IDLE
        en = 1'b0;
        ticks(1);  chk_out("dn_D", 4'b1111, 1'b0, 1'b0);
        ticks(4);  chk("dn_D4.chen", 32'(chen), 32'h7);
        en = 1'b1;
        ticks(4);  chk("dn_D8.chen", 32'(chen), 32'h3);
        ticks(4);  chk("dn_D12.chen", 32'(chen), 32'h1);
        ticks(4);  chk_out("dn_D16", 4'b0000, 1'b0, 1'b0);
        ticks(1);  chk("dn_D17.chen", 32'(chen), 32'h1);
        en = 1'b0;
        ticks(1);  chk("dn_D18.chen", 32'(chen), 32'h1);
        ticks(3);  chk("dn_D21.chen", 32'(chen), 32'h1);
        ticks(1);  chk("dn_D22.chen", 32'(chen), 32'h0);

        // ramp fault on channel 2
        pgood = 4'b0011; en = 1'b1;
        ticks(1);  chk("rf_E.chen", 32'(chen), 32'h1);
        ticks(11); chk_out("rf_E11", 4'b0111, 1'b0, 1'b0);
        ticks(1);  chk_out("rf_E12", 4'b0000, 1'b0, 1'b1);
        ticks(3);  chk_out("rf_hold", 4'b0000, 1'b0, 1'b1);
        en = 1'b0;
        ticks(1);  chk_out("rf_clr", 4'b0000, 1'b0, 1'b0);

        // zero-delay ramp then brown-out on pgood[2]
        pgood = 4'b1111; delay = 8'd0;
        ticks(3);
        en = 1'b1;
        ticks(1);  chk("zd_E.chen", 32'(chen), 32'h1);
        ticks(1);  chk("zd_E1.chen", 32'(chen), 32'h3);
        ticks(1);  chk("zd_E2.chen", 32'(chen), 32'h7);
        ticks(1);  chk_out("zd_E3", 4'b1111, 1'b0, 1'b0);
        ticks(1);  chk_out("zd_E4", 4'b1111, 1'b1, 1'b0);
        pgood = 4'b1011;
        ticks(BL - 1); chk_out("bo_pre", 4'b1111, 1'b1, 1'b0);
        ticks(1);  chk_out("bo_hit", 4'b0000, 1'b0, 1'b1);
        en = 1'b0; pgood = 4'b1111;
        ticks(3);  chk_out("bo_clr", 4'b0000, 1'b0, 1'b0);

        // abort mid-ramp at E+6
        delay = 8'd3; en = 1'b1;
        ticks(1);  chk("ab_E.chen", 32'(chen), 32'h1);
        ticks(5);
        en = 1'b0;
        ticks(1);  chk_out("ab_E6", 4'b0011, 1'b0, 1'b0);
        ticks(4);  chk("ab_E10.chen", 32'(chen), 32'h1);
        ticks(3);  chk("ab_E13.chen", 32'(chen), 32'h1);
        ticks(1);  chk("ab_E14.chen", 32'(chen), 32'h0);

        // reset mid-ramp at E+5, then restart from idx 0
        en = 1'b1;
        ticks(5);  chk("rs_E4.chen", 32'(chen), 32'h3);
        reset = 1'b1;
        ticks(1);  chk_out("rs_E5", 4'b0000, 1'b0, 1'b0);
        reset = 1'b0;
        ticks(1);  chk("rs_restart.chen", 32'(chen), 32'h1);
        ticks(4);  chk("rs_restart4.chen", 32'(chen), 32'h3);

        // delay shrunk below cnt mid-step: cnt wraps through 256
        reset = 1'b1;
        ticks(1);
        reset = 1'b0; delay = 8'd5;
        ticks(1);  chk("wr_E.chen", 32'(chen), 32'h1);
        ticks(4);
        delay = 8'd2;
        ticks(254); chk("wr_E258.chen", 32'(chen), 32'h1);
        ticks(1);   chk("wr_E259.chen", 32'(chen), 32'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/la_iosupseq.md
LA_IOSUPSEQ -- requirements
Module: la_iosupseq

Interface
REQ-001 SHALL have parameter PROP, default "DEFAULT", cell property passed to the implementation library.
REQ-002 SHALL have parameter SIDE, default "NO", ring side: "NO", "SO", "EA" or "WE".
REQ-003 SHALL have parameter RINGW, default 8, io ring width.
REQ-004 SHALL have parameter N, default 4, number of sequenced supply/ground channels (legal range 1..16).
REQ-005 SHALL have parameter DW, default 8, delay counter width.
REQ-006 SHALL have ports: clk  input  1  sole clock, all flops rising-edge.
REQ-007 SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have ports: en  input  1  power-up request; low requests power-down.
REQ-009 SHALL have ports: delay  input  DW  per-step settle time, in cycles.
REQ-010 SHALL have ports: pgood  input  N  per-channel power-good from the analog sense circuits.
REQ-011 SHALL have ports: chen  output  N  per-channel supply/clamp enable, registered.
REQ-012 SHALL have ports: ready  output  1  all channels up, registered.
REQ-013 SHALL have ports: fault  output  1  sticky sequencing fault, registered.
REQ-014 SHALL have ports: vdd, vss, vddio, vssio  inout  1  core/io supplies, and ioring  inout  RINGW  ring bus; all electrically pass-through, with no logic driven onto them.

Function
REQ-015 SHALL implement FSM states IDLE, RAMP, ON, DOWN and FAULT, with internal idx (channel index) and cnt (DW bits).
- IDLE: chen=0 and ready=0.
- en=1 SHALL move the FSM to RAMP with idx=0 and cnt=0.
REQ-016 RAMP behaviour SHALL be:
- chen[j]=1 for all j<=idx.
- cnt SHALL increment each cycle while cnt!=delay.
REQ-017 RAMP step at cnt==delay SHALL be:
- If pgood_s[idx]=1 and idx<N-1: idx+1, cnt=0.
- If pgood_s[idx]=1 and idx==N-1: go to ON.
- If pgood_s[idx]=0: go to FAULT.
REQ-018 Each RAMP step SHALL occupy delay+1 cycles. delay=0 SHALL give one cycle per channel.
REQ-019 ON behaviour SHALL be:
- ready=1 and chen all ones.
- Any pgood_s bit at 0 SHALL move the FSM to FAULT.
- en=0 SHALL move the FSM to DOWN with idx=N-1 and cnt=0.
REQ-020 en=0 during RAMP SHALL move the FSM to DOWN, keeping the current idx, with cnt=0. If en=0 and the fault condition occur in the same cycle, FAULT SHALL win.
REQ-021 DOWN behaviour SHALL be:
- pgood SHALL be ignored and ready=0.
- At cnt==delay, chen[idx] SHALL clear and cnt=0.
- If idx>0, idx SHALL decrement; if idx==0, the FSM SHALL go to IDLE.
- Channels SHALL turn off in reverse order, one per delay+1 cycles.
REQ-022 en=1 during DOWN SHALL be ignored until IDLE is reached.
REQ-023 FAULT behaviour SHALL be:
- chen=0 and ready=0 on the entry edge.
- fault=1 while in FAULT.
- The FSM SHALL leave FAULT for IDLE only when en=0 is sampled; fault SHALL clear on that edge.
REQ-024 A change of delay mid-step SHALL take effect on the next comparison. If cnt already exceeds the new delay, cnt SHALL wrap through 2^DW before matching.
REQ-025 pgood_s SHALL be pgood as defined by the Configuration section.

Reset
REQ-026 reset=1 at a rising clk edge SHALL force state=IDLE, idx=0, cnt=0, chen=0, ready=0, fault=0, and clear any synchronizer flops, from any state (including mid-RAMP/DOWN).
REQ-027 reset SHALL take priority over all other inputs.

Configuration
REQ-028 With LA_IOSUPSEQ_SYNC_EN defined, pgood_s SHALL be pgood passed through a 2-flop synchronizer, adding 2 cycles of sense latency.
REQ-029 Without LA_IOSUPSEQ_SYNC_EN, pgood_s SHALL equal pgood directly, and pgood is then required to be synchronous to clk.

Verification (N=4, DW=8, delay=3, pgood held stable 3+ cycles before sampling)
REQ-030 Power-up scenario: en=1 sampled at edge E, all pgood=1.
- Required response: chen=0001 after E, 0011 after E+4, 0111 after E+8, 1111 after E+12.
- ready=1 after E+16.
REQ-031 Power-down scenario: from ON, en=0 at edge D.
- Required response: chen=0111 after D+4, 0011 after D+8, 0001 after D+12, 0000 and IDLE after D+16.
- ready=0 after D.
REQ-032 Ramp fault scenario: pgood=0011, en=1.
- Required response: FAULT at E+12, chen=0000, fault=1.
- fault stays 1 while en=1 and clears after en=0 is sampled.
REQ-033 Brown-out scenario: in ON, pgood[2] drops to 0.
- Required response: FAULT, chen=0000 within 1 cycle of pgood_s (3 with SYNC_EN), ready=0.
REQ-034 Abort and reset scenario:
- en=0 at E+6: DOWN from idx=1; chen=0001 after E+10, 0000 after E+14.
- reset=1 at E+5: all outputs 0 after that edge.
REQ-035 Zero-delay scenario: delay=0.
- Required response: chen=0001,0011,0111,1111 on consecutive cycles; ready=1 after E+4.
